// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: bus widths, sequencer state and owner encodings.
package mem_port_arbiter_pkg;

   localparam int ASIZE = 32;
   localparam int DSIZE = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of mem_port_arbiter.
// The arbiter uses the slave modport; the requesters and memory model use master.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic             if_req;
   logic [ASIZE-1:0] if_addr;
   logic [DSIZE-1:0] if_rdata;
   logic             if_ack;

   logic             dm_req;
   logic             dm_we;
   logic [ASIZE-1:0] dm_addr;
   logic [DSIZE-1:0] dm_wdata;
   logic [DSIZE-1:0] dm_rdata;
   logic             dm_ack;

   logic             mem_en;
   logic             mem_we;
   logic [ASIZE-1:0] mem_addr;
   logic [DSIZE-1:0] mem_wdata;
   logic [DSIZE-1:0] mem_rdata;

   logic             stall_if;
   logic             stall_mem;

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ack, dm_rdata, dm_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ack, dm_rdata, dm_ack,
      output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between fetch and data requests.
// With ARB_RR_EN the port not granted last wins a tie; otherwise DM always wins ties.
module mem_port_arbiter_arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic   if_req,
   input  logic   dm_req,
`ifdef ARB_RR_EN
   input  owner_t last_grant,
`endif
   output owner_t winner
);

   // Winner is only meaningful while at least one request is present.
   always_comb begin
      winner = OWNER_IF;
      if (if_req && dm_req) begin
`ifdef ARB_RR_EN
         if (last_grant == OWNER_DM) begin
            winner = OWNER_IF;
         end else begin
            winner = OWNER_DM;
         end
`else
         winner = OWNER_DM;
`endif
      end else if (dm_req) begin
         winner = OWNER_DM;
      end else begin
         winner = OWNER_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between IF and MEM through an IDLE/LAUNCH/WAIT/DONE sequencer.
// Build option ARB_RR_EN selects round-robin tie-breaking instead of DM-first priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t           state_r;
   owner_t           owner_r;
   logic             we_r;
   logic [3:0]       cnt_r;
   logic             mem_en_r;
   logic             mem_we_r;
   logic [ASIZE-1:0] mem_addr_r;
   logic [DSIZE-1:0] mem_wdata_r;
   logic [DSIZE-1:0] if_rdata_r;
   logic [DSIZE-1:0] dm_rdata_r;
   logic             if_ack_r;
   logic             dm_ack_r;
   owner_t           pick_s;
   logic             any_req_s;

`ifdef ARB_RR_EN
   owner_t           last_grant_r;
`endif

   assign any_req_s = bus.if_req | bus.dm_req;

   mem_port_arbiter_arb_pick u_arb_pick (
      .if_req     (bus.if_req),
      .dm_req     (bus.dm_req),
`ifdef ARB_RR_EN
      .last_grant (last_grant_r),
`endif
      .winner     (pick_s)
   );

   // Transaction sequencer; every output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         owner_r     <= OWNER_IF;
         we_r        <= 1'b0;
         cnt_r       <= 4'd0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ASIZE{1'b0}};
         mem_wdata_r <= {DSIZE{1'b0}};
         if_rdata_r  <= {DSIZE{1'b0}};
         dm_rdata_r  <= {DSIZE{1'b0}};
         if_ack_r    <= 1'b0;
         dm_ack_r    <= 1'b0;
`ifdef ARB_RR_EN
         last_grant_r <= OWNER_IF;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  owner_r  <= pick_s;
                  mem_en_r <= 1'b1;
`ifdef ARB_RR_EN
                  last_grant_r <= pick_s;
`endif
                  if (pick_s == OWNER_DM) begin
                     we_r        <= bus.dm_we;
                     mem_we_r    <= bus.dm_we;
                     mem_addr_r  <= bus.dm_addr;
                     mem_wdata_r <= bus.dm_wdata;
                  end else begin
                     // Fetch is always a read; store data from the last write is kept.
                     we_r       <= 1'b0;
                     mem_we_r   <= 1'b0;
                     mem_addr_r <= bus.if_addr;
                  end
                  state_r <= ST_LAUNCH;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
               cnt_r    <= CNT_LOAD;
               state_r  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  if (owner_r == OWNER_DM) begin
                     dm_ack_r <= 1'b1;
                     if (!we_r) begin
                        dm_rdata_r <= bus.mem_rdata;
                     end
                  end else begin
                     if_ack_r   <= 1'b1;
                     if_rdata_r <= bus.mem_rdata;
                  end
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               if_ack_r <= 1'b0;
               dm_ack_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
               if_ack_r <= 1'b0;
               dm_ack_r <= 1'b0;
               cnt_r    <= 4'd0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.dm_rdata  = dm_rdata_r;
   assign bus.if_ack    = if_ack_r;
   assign bus.dm_ack    = dm_ack_r;

   // Stalls release in the ack cycle so the stage advances on the same edge the ack drops.
   assign bus.stall_if  = bus.if_req & ~if_ack_r;
   assign bus.stall_mem = bus.dm_req & ~dm_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model plus directed literal checks.
module tb_mem_port_arbiter;

   localparam int L = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_port_arbiter_if bus ();
   mem_port_arbiter_if bus1 ();

   mem_port_arbiter #(.MEM_LAT(L)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int c = 0;

   // Reference model: one transaction record, timed from its grant cycle.
   bit          tv;
   int          t;
   int          t_end;
   bit          own;
   bit          twe;
   bit          last;
   logic [31:0] m_addr, m_wdata, m_ifrd, m_dmrd;

   logic        s_en, s_we, s_ifack, s_dmack, s_stall_if, s_stall_mem;
   logic [31:0] s_addr, s_wdata, s_ifrd, s_dmrd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, c);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, c);
      end
   endtask

   task automatic model_reset();
      tv = 1'b0; t = 0; t_end = 0; own = 1'b0; twe = 1'b0; last = 1'b0;
      m_addr = 32'd0; m_wdata = 32'd0; m_ifrd = 32'd0; m_dmrd = 32'd0;
   endtask

   function automatic bit tie_winner_dm(input bit last_was_dm);
`ifdef ARB_RR_EN
      return !last_was_dm;
`else
      return last_was_dm | 1'b1;
`endif
   endfunction

   // One cycle: compare against the model at negedge, advance the model, move to next cycle.
   task automatic step();
      logic e_en, e_ifack, e_dmack;
      @(negedge clk);
      e_en    = tv && (c == t + 1);
      e_ifack = tv && !own && (c == t + 2 + L);
      e_dmack = tv && own && (c == t + 2 + L);
      chk1("mem_en", bus.mem_en, e_en);
      chk1("mem_we", bus.mem_we, e_en && twe);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("if_rdata", bus.if_rdata, m_ifrd);
      chk("dm_rdata", bus.dm_rdata, m_dmrd);
      chk1("if_ack", bus.if_ack, e_ifack);
      chk1("dm_ack", bus.dm_ack, e_dmack);
      chk1("stall_if", bus.stall_if, bus.if_req & ~e_ifack);
      chk1("stall_mem", bus.stall_mem, bus.dm_req & ~e_dmack);
      s_en = bus.mem_en; s_we = bus.mem_we; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
      s_ifrd = bus.if_rdata; s_dmrd = bus.dm_rdata; s_ifack = bus.if_ack; s_dmack = bus.dm_ack;
      s_stall_if = bus.stall_if; s_stall_mem = bus.stall_mem;
      if (rst) begin
         model_reset();
      end else begin
         if (tv && (c == t + 1 + L) && !twe) begin
            if (own) m_dmrd = bus.mem_rdata;
            else     m_ifrd = bus.mem_rdata;
         end
         if ((c >= t_end) && (bus.if_req || bus.dm_req)) begin
            if (bus.if_req && bus.dm_req) own = tie_winner_dm(last);
            else                          own = bus.dm_req;
            tv = 1'b1; t = c; t_end = c + 3 + L; last = own;
            if (own) begin
               twe = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
            end else begin
               twe = 1'b0; m_addr = bus.if_addr;
            end
         end
      end
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic drop_on_ack();
      if (s_ifack) bus.if_req = 1'b0;
      if (s_dmack) bus.dm_req = 1'b0;
   endtask

   int          k_if, k_dm;
   logic [31:0] rd1 [0:19];

   initial begin
      bus.if_req = 1'b1; bus.if_addr = 32'd0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0; bus.mem_rdata = 32'd0;
      bus1.if_req = 1'b0; bus1.if_addr = 32'd0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
      bus1.dm_addr = 32'd0; bus1.dm_wdata = 32'd0; bus1.mem_rdata = 32'd0;
      s_ifack = 1'b0; s_dmack = 1'b0;
      model_reset();

      // Reset state with a fetch request pending.
      #2;
      chk1("rst_mem_en", bus.mem_en, 1'b0);
      chk1("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
      chk1("rst_if_ack", bus.if_ack, 1'b0);
      chk1("rst_dm_ack", bus.dm_ack, 1'b0);
      chk1("rst_stall_if", bus.stall_if, 1'b1);
      chk1("rst_stall_mem", bus.stall_mem, 1'b0);
      @(posedge clk);
      #1;
      bus.if_req = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // IF read of 0x40, memory answers 0xDEADBEEF three cycles after the request.
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      for (int k = 0; k < 5; k++) begin
         drop_on_ack();
         bus.mem_rdata = (k == 3) ? 32'hDEADBEEF : $urandom;
         step();
         chk1("t2_mem_en", s_en, k == 1);
         chk1("t2_stall_if", s_stall_if, k < 4);
         chk1("t2_if_ack", s_ifack, k == 4);
         if (k == 1) chk("t2_mem_addr", s_addr, 32'h40);
         if (k == 4) chk("t2_if_rdata", s_ifrd, 32'hDEADBEEF);
      end
      drop_on_ack();
      step();

      // DM write of 0x55 to 0x100.
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'h55;
      for (int k = 0; k < 5; k++) begin
         drop_on_ack();
         bus.mem_rdata = $urandom;
         step();
         chk1("t3_mem_en", s_en, k == 1);
         chk1("t3_dm_ack", s_dmack, k == 4);
         if (k == 1) begin
            chk1("t3_mem_we", s_we, 1'b1);
            chk("t3_mem_addr", s_addr, 32'h100);
            chk("t3_mem_wdata", s_wdata, 32'h55);
         end
         if (k == 4) chk("t3_dm_rdata", s_dmrd, 32'd0);
      end
      drop_on_ack();
      step();

      // Simultaneous requests; last grant was DM.
`ifdef ARB_RR_EN
      k_if = 1; k_dm = 6;
`else
      k_if = 6; k_dm = 1;
`endif
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
      for (int k = 0; k < 10; k++) begin
         drop_on_ack();
         bus.mem_rdata = $urandom;
         step();
         chk1("t4_mem_en", s_en, (k == k_if) || (k == k_dm));
         chk1("t4_if_ack", s_ifack, k == k_if + 3);
         chk1("t4_dm_ack", s_dmack, k == k_dm + 3);
         if (k == k_if) chk("t4_if_addr", s_addr, 32'h80);
         if (k == k_dm) chk("t4_dm_addr", s_addr, 32'h200);
      end
      drop_on_ack();
      step();

      // Reset while the sequencer waits on memory.
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      step();
      step();
      rst = 1'b1;
      #1;
      chk1("t5_mem_en", bus.mem_en, 1'b0);
      chk("t5_mem_addr", bus.mem_addr, 32'd0);
      chk("t5_mem_wdata", bus.mem_wdata, 32'd0);
      chk("t5_if_rdata", bus.if_rdata, 32'd0);
      chk("t5_dm_rdata", bus.dm_rdata, 32'd0);
      chk1("t5_if_ack", bus.if_ack, 1'b0);
      model_reset();
      bus.if_req = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      bus.if_req = 1'b1; bus.if_addr = 32'h44;
      for (int k = 0; k < 5; k++) begin
         drop_on_ack();
         bus.mem_rdata = $urandom;
         step();
         chk1("t5_fresh_ack", s_ifack, k == 4);
      end
      drop_on_ack();
      step();

      // Randomized requesters, including requests dropped before or after a grant.
      for (int i = 0; i < 1500; i++) begin
         if (bus.if_req && s_ifack) bus.if_req = 1'b0;
         else if (bus.if_req && ($urandom_range(0, 31) == 0)) bus.if_req = 1'b0;
         else if (!bus.if_req && ($urandom_range(0, 2) == 0)) begin
            bus.if_req = 1'b1; bus.if_addr = $urandom;
         end
         if (bus.dm_req && s_dmack) bus.dm_req = 1'b0;
         else if (bus.dm_req && ($urandom_range(0, 31) == 0)) bus.dm_req = 1'b0;
         else if (!bus.dm_req && ($urandom_range(0, 2) == 0)) begin
            bus.dm_req = 1'b1; bus.dm_we = 1'($urandom_range(0, 1));
            bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
         end
         bus.mem_rdata = $urandom;
         step();
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;

      // MEM_LAT=1 instance with fetch held high: one ack every 4 cycles.
      bus1.if_req = 1'b1; bus1.if_addr = 32'h1000;
      for (int k = 0; k < 20; k++) begin
         rd1[k] = $urandom;
         bus1.mem_rdata = rd1[k];
         @(negedge clk);
         chk1("t6_mem_en", bus1.mem_en, (k % 4) == 1);
         chk1("t6_if_ack", bus1.if_ack, (k % 4) == 3);
         if ((k % 4) == 3) chk("t6_if_rdata", bus1.if_rdata, rd1[k-1]);
         @(posedge clk);
         #1;
      end
      bus1.if_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency memory between instruction fetch (IF) and the data-memory access of the MEM stage, downstream of the EXE/MEM pipeline register. Runs one transaction at a time through a four-state sequencer. Returns read data and a one-cycle acknowledge to the winning requester. Drives stall outputs that freeze the corresponding pipeline stage until its access completes.

## Interface
- ASIZE, 32, address width (the shared address-width constant)
- DSIZE, 32, data width (the shared data-width constant)
- MEM_LAT, 2, memory read latency in cycles, legal range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ASIZE  fetch address
- if_rdata  out  DSIZE  fetched word
- if_ack  out  1  fetch complete, one-cycle pulse
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ASIZE  data address (ALU result)
- dm_wdata  in  DSIZE  store data
- dm_rdata  out  DSIZE  load data
- dm_ack  out  1  data access complete, one-cycle pulse
- mem_en  out  1  memory launch strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ASIZE  memory address
- mem_wdata  out  DSIZE  memory write data
- mem_rdata  in  DSIZE  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  dm_req & ~dm_ack (combinational)

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE: if any request is present, pick a winner, latch owner/address/we/wdata, go to LAUNCH; otherwise stay.
- LAUNCH: mem_en=1 and mem_we=owner_we for this one cycle only; load cnt=MEM_LAT-1; go to WAIT.
- WAIT: if cnt!=0, decrement. If cnt==0, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE: pulse the owner's ack; go to IDLE. No grant is decided in DONE.
- Requests dropped before the grant are ignored. Once granted, a transaction always completes and acks, even if req drops.
- if_rdata/dm_rdata hold their value until the next read capture for that port. A DM write acks without changing dm_rdata.
- mem_addr/mem_wdata are registered and hold between transactions; mem_we is 0 outside LAUNCH.
- IF is always a read; mem_we=0 for IF grants.
- cnt is 4 bits wide.
- Reset (async, any state, including mid-transaction): state=IDLE; cnt=0; every output register=0 (mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ack, dm_ack); last_grant=IF. An in-flight transaction is dropped with no ack.

## Timing
- Request seen in IDLE at cycle T: LAUNCH at T+1, data at T+1+MEM_LAT, ack at T+2+MEM_LAT.
- Request-to-ack latency is MEM_LAT+2 cycles, for reads and writes alike.
- Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Stall outputs are high from the request cycle through the cycle before ack, and low in the ack cycle.

## Configuration
- ARB_RR_EN defined: on simultaneous requests in IDLE, the port not granted last wins; a last_grant register is updated at each grant.
- ARB_RR_EN undefined: fixed priority, DM always wins ties (the older instruction goes first); no last_grant register.

## Structure
- The shared definitions package holds ASIZE/DSIZE defaults, the state encoding (2-bit: IDLE=0, LAUNCH=1, WAIT=2, DONE=3) and the owner encoding (IF=0, DM=1).
- One sub-module is natural: arb_pick, the combinational winner select taking if_req, dm_req and last_grant.

## Test plan
- Reset pulse mid-idle -> all outputs 0 and stalls follow requests; state IDLE.
- MEM_LAT=2, if_req with if_addr=0x40 at T, memory returns 0xDEADBEEF at T+3 -> mem_en only at T+1 with addr 0x40; if_ack at T+4 with if_rdata=0xDEADBEEF; stall_if high T..T+3.
- dm write, addr 0x100, wdata 0x55 -> mem_en=mem_we=1 at T+1 with those values; dm_ack at T+4; dm_rdata unchanged.
- if_req and dm_req both raised at T -> DM launches at T+1 and IF at T+6. With ARB_RR_EN and last_grant=DM, IF launches first instead.
- rst asserted during WAIT -> outputs 0 immediately with no ack; a fresh if_req after release acks after MEM_LAT+2 cycles.
- MEM_LAT=1, if_req held continuously -> if_ack every 4 cycles, with each if_rdata matching its mem_rdata.
